// File: rtl/phylog_pkg.sv
// rtl/phylog_pkg.sv - shared op-bus field positions, opcodes and task state encodings
package phylog_pkg;

    // op bus fields: [15:12] unused, [11:8] target id, [7:4] opcode, [3:0] argument
    localparam int OP_ID_HI   = 11;
    localparam int OP_ID_LO   = 8;
    localparam int OP_CODE_HI = 7;
    localparam int OP_CODE_LO = 4;
    localparam int OP_ARG_HI  = 3;
    localparam int OP_ARG_LO  = 0;

    localparam logic [3:0] OP_READY    = 4'b0001;
    localparam logic [3:0] OP_SUSPEND  = 4'b0010;
    localparam logic [3:0] OP_WAIT     = 4'b0011;
    localparam logic [3:0] OP_KILL     = 4'b0100;
    localparam logic [3:0] OP_KILL_ALT = 4'b1100;
    localparam logic [3:0] OP_SETPRIO  = 4'b0101;
    localparam logic [3:0] OP_SETHIT   = 4'b0110;
    localparam logic [3:0] OP_EXEC     = 4'b0111;
    localparam logic [3:0] OP_FINISH   = 4'b1111;

    localparam logic [1:0] ST_READY = 2'b00;
    localparam logic [1:0] ST_SUSP  = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;
    localparam logic [1:0] ST_TERM  = 2'b11;

    // opcodes a task control block reacts to; anything else is bus noise
    function automatic logic op_is_known(input logic [3:0] code);
        case (code)
            OP_READY, OP_SUSPEND, OP_WAIT, OP_KILL, OP_KILL_ALT,
            OP_SETPRIO, OP_SETHIT, OP_EXEC, OP_FINISH: op_is_known = 1'b1;
            default:                                   op_is_known = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_kill(input logic [3:0] code);
        op_is_kill = (code == OP_KILL) || (code == OP_KILL_ALT);
    endfunction

endpackage

// File: rtl/task_aging_timer.sv
// rtl/task_aging_timer.sv - counts eligible idle cycles and ticks once per aging period
module task_aging_timer #(
    parameter int unsigned AGING_PERIOD = 10000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (AGING_PERIOD > 1) ? $clog2(AGING_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'((AGING_PERIOD > 0) ? AGING_PERIOD - 1 : 0);
    localparam logic ACTIVE = (AGING_PERIOD != 0);

    logic [CW-1:0] count;

    // wrap is combinational so the priority bump lands on the same edge as the wrap
    assign tick = ACTIVE && enable && !clear && (count == LAST);

    // count while enabled, hold otherwise; a clear always restarts the period
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (ACTIVE && enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/task_tcb.sv
// rtl/task_tcb.sv - per-task control block decoding the broadcast op bus for the sorter
module task_tcb
    import phylog_pkg::*;
#(
    parameter logic [3:0]  TASK_ID      = 4'd9,
    parameter int unsigned PRIO_W       = 4,
    parameter int unsigned HIT_W        = 8,
    parameter int unsigned HIT_INIT     = 128,
    parameter int unsigned AGING_PERIOD = 10000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [15:0]         in_op,
    output logic [4+PRIO_W-1:0] out_sorter,
    output logic                out_valid,
    output logic                op_ack,
    output logic [1:0]          task_state
);

    localparam logic [PRIO_W-1:0] PRIO_MAX = {PRIO_W{1'b1}};

    logic [3:0] op_id;
    logic [3:0] op_code;
    logic [3:0] op_arg;

    logic [1:0]        state_q, state_d;
    logic [PRIO_W-1:0] prio_q, prio_d;
    logic [HIT_W-1:0]  hit_q, hit_d;

    logic                eligible;
    logic                addressed;
    logic                exec_ok;
    logic                age_clear;
    logic                age_enable;
    logic                age_tick;
    logic [4+PRIO_W-1:0] sorter_d;
    logic                valid_d;

    assign op_id   = in_op[OP_ID_HI:OP_ID_LO];
    assign op_code = in_op[OP_CODE_HI:OP_CODE_LO];
    assign op_arg  = in_op[OP_ARG_HI:OP_ARG_LO];

    assign eligible = (state_q == ST_READY) && (hit_q != '0);

    // a terminated task only listens for further kills
    assign addressed = (op_id == TASK_ID) && op_is_known(op_code)
                       && ((state_q != ST_TERM) || op_is_kill(op_code));

    assign exec_ok    = addressed && ((op_code == OP_EXEC) || (op_code == OP_FINISH)) && eligible;
    assign age_clear  = (addressed && (op_code == OP_SETPRIO)) || exec_ok;
    assign age_enable = eligible && !addressed;

    task_aging_timer #(
        .AGING_PERIOD(AGING_PERIOD)
    ) u_aging (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .enable (age_enable),
        .clear  (age_clear),
        .tick   (age_tick)
    );

    // state register: task state, priority and remaining hits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_READY;
            prio_q  <= '0;
            hit_q   <= HIT_W'(HIT_INIT);
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            hit_q   <= hit_d;
        end
    end

    // next state: addressed ops take priority over the aging bump
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        hit_d   = hit_q;
        if (addressed) begin
            case (op_code)
                OP_READY:             state_d = ST_READY;
                OP_SUSPEND:           state_d = ST_SUSP;
                OP_WAIT:              state_d = ST_WAIT;
                OP_KILL, OP_KILL_ALT: state_d = ST_TERM;
                OP_SETPRIO:           prio_d  = PRIO_W'(op_arg);
                OP_SETHIT:            hit_d   = HIT_W'(op_arg);
                OP_EXEC, OP_FINISH: begin
                    if (exec_ok) begin
                        hit_d = hit_q - HIT_W'(1);
                        if ((op_code == OP_FINISH) && (hit_q == HIT_W'(1))) begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end else if (age_tick && (prio_q != PRIO_MAX)) begin
            prio_d = prio_q + PRIO_W'(1);
        end
    end

    // output decode from the current (pre-update) state
    always_comb begin
        sorter_d = '0;
        valid_d  = 1'b0;
        if (eligible) begin
            sorter_d = {TASK_ID, prio_q};
            valid_d  = 1'b1;
        end
    end

    // registered outputs toward the sorter plus the op acknowledge pulse
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_sorter <= '0;
            out_valid  <= 1'b0;
            op_ack     <= 1'b0;
        end else begin
            out_sorter <= sorter_d;
            out_valid  <= valid_d;
            op_ack     <= addressed;
        end
    end

    assign task_state = state_q;

endmodule

// File: tb/tb_task_tcb.sv
// tb/tb_task_tcb.sv - scoreboard bench for task_tcb with a short aging period
module tb_task_tcb;

    logic        CLK;
    logic        RST_N;
    logic [15:0] in_op;
    logic [7:0]  out_sorter;
    logic        out_valid;
    logic        op_ack;
    logic [1:0]  task_state;

    int n_cmp = 0;
    int n_err = 0;

    // expected {out_sorter, out_valid, op_ack, task_state}
    logic [11:0] exp_q[$];
    logic [11:0] got;
    logic [11:0] e;

    task_tcb #(
        .TASK_ID      (4'd9),
        .PRIO_W       (4),
        .HIT_W        (8),
        .HIT_INIT     (128),
        .AGING_PERIOD (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_op      (in_op),
        .out_sorter (out_sorter),
        .out_valid  (out_valid),
        .op_ack     (op_ack),
        .task_state (task_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input logic [15:0] op);
        in_op = op;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        in_op = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        exp_q.push_back({8'h00, 1'b0, 1'b0, 2'b00});
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", got, e);
        end
        RST_N = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({8'h90, 1'b1, 1'b0, 2'b00});
            tick(16'h0000);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset_release[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_prio_suspend();
        logic [15:0] ops [3] = '{16'h0957, 16'h0920, 16'h0000};
        logic [11:0] exps[3] = '{{8'h90, 1'b1, 1'b1, 2'b00},
                                 {8'h97, 1'b1, 1'b1, 2'b01},
                                 {8'h00, 1'b0, 1'b0, 2'b01}};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            tick(ops[i]);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL prio_suspend[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_exec_finish();
        logic [15:0] ops [8] = '{16'h0910, 16'h0962, 16'h09F0, 16'h09F0,
                                 16'h09F0, 16'h0000, 16'h0910, 16'h0000};
        logic [11:0] exps[8] = '{{8'h00, 1'b0, 1'b1, 2'b00},
                                 {8'h97, 1'b1, 1'b1, 2'b00},
                                 {8'h97, 1'b1, 1'b1, 2'b00},
                                 {8'h97, 1'b1, 1'b1, 2'b10},
                                 {8'h00, 1'b0, 1'b1, 2'b10},
                                 {8'h00, 1'b0, 1'b0, 2'b10},
                                 {8'h00, 1'b0, 1'b1, 2'b00},
                                 {8'h00, 1'b0, 1'b0, 2'b00}};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exps[i]);
            tick(ops[i]);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL exec_finish[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_aging();
        logic [15:0] sup_ops [7] = '{16'h095E, 16'h0000, 16'h0000, 16'h0000,
                                     16'h0910, 16'h0000, 16'h0000};
        logic [7:0]  sup_srt [7] = '{8'h9F, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9E, 8'h9F};
        // one hit, priority 14
        exp_q.push_back({8'h00, 1'b0, 1'b1, 2'b00});
        tick(16'h0961);
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL aging_sethit: got %h expected %h", got, e);
        end
        exp_q.push_back({8'h97, 1'b1, 1'b1, 2'b00});
        tick(16'h095E);
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL aging_setprio: got %h expected %h", got, e);
        end
        // idle: bump after four eligible cycles, then saturate
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({(i < 4) ? 8'h9E : 8'h9F, 1'b1, 1'b0, 2'b00});
            tick(16'h0000);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL aging_idle[%0d]: got %h expected %h", i, got, e);
            end
        end
        // addressed op on the wrap cycle delays the bump by one cycle
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({sup_srt[i], 1'b1, (i == 0 || i == 4), 2'b00});
            tick(sup_ops[i]);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL aging_suppress[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_unaddressed();
        logic [15:0] ops [4] = '{16'h0320, 16'h0980, 16'h0900, 16'h0940 & 16'h0F0F};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'h9F, 1'b1, 1'b0, 2'b00});
            tick(ops[i]);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL unaddressed[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_kill();
        logic [15:0] ops [4] = '{16'h0940, 16'h0910, 16'h09C0, 16'h0957};
        logic [11:0] exps[4] = '{{8'h9F, 1'b1, 1'b1, 2'b11},
                                 {8'h00, 1'b0, 1'b0, 2'b11},
                                 {8'h00, 1'b0, 1'b1, 2'b11},
                                 {8'h00, 1'b0, 1'b0, 2'b11}};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exps[i]);
            tick(ops[i]);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL kill[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        // mid-cycle reset out of Terminated
        #2;
        RST_N = 1'b0;
        #1;
        exp_q.push_back({8'h00, 1'b0, 1'b0, 2'b00});
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL async_reset_term: got %h expected %h", got, e);
        end
        in_op = 16'h0000;
        #1;
        RST_N = 1'b1;
        // start an execute sequence, then reset between edges
        exp_q.push_back({8'h90, 1'b1, 1'b1, 2'b00});
        tick(16'h0962);
        exp_q.push_back({8'h90, 1'b1, 1'b1, 2'b00});
        tick(16'h09F0);
        for (int i = 0; i < 2; i++) begin
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            if (i == 1) begin
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL exec_before_reset: got %h expected %h", got, e);
                end
            end
        end
        #2;
        RST_N = 1'b0;
        #1;
        exp_q.push_back({8'h00, 1'b0, 1'b0, 2'b00});
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL async_reset_exec: got %h expected %h", got, e);
        end
        in_op = 16'h0000;
        #1;
        RST_N = 1'b1;
        // hits restored to 128: the 128th finish is the one that enters Wait
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back({8'h90, 1'b1, 1'b1, (i == 127) ? 2'b10 : 2'b00});
            tick(16'h09F0);
            got = {out_sorter, out_valid, op_ack, task_state};
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL hit_init_finish[%0d]: got %h expected %h", i, got, e);
            end
        end
        exp_q.push_back({8'h00, 1'b0, 1'b0, 2'b10});
        tick(16'h0000);
        got = {out_sorter, out_valid, op_ack, task_state};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL hit_init_wait: got %h expected %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_prio_suspend();
        test_exec_finish();
        test_aging();
        test_unaddressed();
        test_kill();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/task_tcb.md
Name: task_tcb

Overview:
- Parametrised task control block; the next generation of the fixed-ID per-task modules.
- Decodes the 16-bit broadcast operation bus and keeps per-task state, priority and remaining execution hits.
- Ages priority while the task waits to run.
- Presents {task id, priority} to the downstream sorter; one instance per task, all on the shared op bus.

Parameters:
- TASK_ID, 4'd9, task identifier matched against in_op[11:8].
- PRIO_W, 4, priority width (>=4); out_sorter width is 4+PRIO_W.
- HIT_W, 8, execution-hit counter width (>=4).
- HIT_INIT, 128, exe_hit reset value (must fit HIT_W).
- AGING_PERIOD, 10000, cycles spent eligible before priority +1; 0 disables aging.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_op  in  16  operation: [15:12] ignored, [11:8] target id, [7:4] opcode, [3:0] argument.
- out_sorter  out  4+PRIO_W  {TASK_ID, priority} when eligible, else all zero; registered.
- out_valid  out  1  high when out_sorter carries an eligible task.
- op_ack  out  1  one-cycle pulse the cycle after an addressed op was accepted (any opcode below, including ignored execute).
- task_state  out  2  current state: 00 Ready, 01 Suspended, 10 Wait, 11 Terminated.

Behaviour:
- Reset (async assert, sync release):
  - state=Ready, priority=0, exe_hit=HIT_INIT, aging count=0.
  - out_sorter=0, out_valid=0, op_ack=0.
- Addressing: an op is addressed only when in_op[11:8]==TASK_ID and the opcode is listed below. Everything else holds all state and gives no op_ack.
- Opcodes (all effects visible the cycle after the op is sampled):
  - 0001 Ready -> state Ready.
  - 0010 Suspend -> state Suspended.
  - 0011 Wait -> state Wait.
  - 0100 or 1100 Kill -> state Terminated.
  - 0101 Set priority -> priority = zero-extended arg; aging count cleared.
  - 0110 Set hits -> exe_hit = zero-extended arg.
  - 0111 Execute -> if state==Ready and exe_hit>0: exe_hit-1, aging count cleared; otherwise no change, op_ack still pulses.
  - 1111 Finish -> as Execute; additionally, if exe_hit goes 1->0, state -> Wait.
- Terminated is sticky: every op except Kill is ignored (no op_ack) until reset.
- Eligible = state==Ready and exe_hit>0.
- Aging:
  - Counter increments each cycle while eligible and no addressed op is sampled.
  - On reaching AGING_PERIOD-1 it wraps to 0 and priority increments, saturating at 2^PRIO_W-1.
  - Counter holds (does not clear) while not eligible.
  - If an addressed op and the wrap occur in the same cycle, the op wins and aging skips that cycle.
- Output (registered from current state): out_sorter={TASK_ID, priority} and out_valid=1 when eligible, else 0/0.
  - Latency: op sampled at edge N -> state updates at N -> out_sorter reflects it at edge N+1.
- exe_hit never underflows.
- Set hits with arg 0 makes the task ineligible without changing state.
- Reset asserted mid-operation clears everything immediately, regardless of CLK.

Decomposition:
- Shared package phylog_pkg:
  - opcode localparams: OP_READY, OP_SUSPEND, OP_WAIT, OP_KILL, OP_KILL_ALT, OP_SETPRIO, OP_SETHIT, OP_EXEC, OP_FINISH;
  - state encodings ST_READY, ST_SUSP, ST_WAIT, ST_TERM;
  - op-field bit positions.
- One sub-module, task_aging_timer (parameter AGING_PERIOD; inputs enable/clear; output one-cycle tick), instanced once.

Test Plan:
- Reset release, no ops -> at the second edge, out_sorter=8'h90, out_valid=1, task_state=00, op_ack=0.
- in_op=16'h0957 (set prio 7), then 16'h0920 (suspend) -> out_sorter=8'h97 then 8'h00; op_ack pulses once per op.
- in_op=16'h0962 (hits=2), then two 16'h09F0 -> exe_hit 1 then 0, state Wait, out_valid=0; a third 16'h09F0 leaves all state unchanged, op_ack=1.
- AGING_PERIOD=4, prio=14, idle Ready -> priority 15 after 4 cycles, still 15 after 8 (saturation); an op on the wrap cycle suppresses that increment.
- in_op=16'h0940 then 16'h0910 -> Terminated, second op ignored, no op_ack; ops with id 4'h3 or opcode 1000 never change state.
- RST_N asserted between edges during an execute sequence -> outputs 0 immediately; exe_hit returns to HIT_INIT.
